// File: rtl/btn_press_detect_pkg.sv
// Shared types and helpers for the push-button front end and the LED blink stage.
// States are listed in the order the FSM walks through a press.
package btn_press_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG_HELD,
    REL_DB
  } btn_state_t;

  // Milliseconds to clock cycles; divide first so 50 MHz * 1000 ms fits in 32 bits.
  function automatic int ms_to_cycles(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_press_detect_if.sv
// Raw button pin in, debounced level and press-class strobes out.
// master is the detector side; slave is the consumer (blink stage or bench).
interface btn_press_detect_if;

  logic btn_in;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic hold;

  modport master (
    input  btn_in,
    output btn_level,
    output short_press,
    output long_press,
    output hold
  );

  modport slave (
    output btn_in,
    input  btn_level,
    input  short_press,
    input  long_press,
    input  hold
  );

endinterface

// File: rtl/btn_press_detect_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; two cycles of latency.
// RST_VAL lets the flops come out of reset at the input's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_press_detect.sv
// Synchronises, debounces and classifies one push-button as short or long press.
// btn_level follows a stable press/release after DB_CYCLES+3 edges; all outputs registered.
module btn_press_detect
  import btn_press_detect_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  btn_press_detect_if.master bus
);

  // Valid only for DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES.
  localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int DB_W        = cnt_width(DB_CYCLES);
  localparam int LONG_W      = cnt_width(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic btn_sync;
  logic p;

  btn_state_t        state, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic [LONG_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              level_q, level_nxt;
  logic              hold_q, hold_nxt;
  logic              short_q, short_nxt;
  logic              long_q, long_nxt;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (btn_sync)
  );

  assign p = btn_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      level_q  <= 1'b0;
      hold_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      level_q  <= level_nxt;
      hold_q   <= hold_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
    end
  end

  // hold_q doubles as the "this press already went long" flag while in REL_DB.
  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    hold_cnt_nxt = hold_cnt;
    level_nxt    = level_q;
    hold_nxt     = hold_q;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (p) begin
          state_nxt  = PRESS_DB;
          db_cnt_nxt = '0;
        end
      end

      PRESS_DB: begin
        if (!p) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = HELD;
          level_nxt    = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end

      HELD: begin
        // A release seen on the same edge as the long threshold takes priority.
        if (!p) begin
          state_nxt  = REL_DB;
          db_cnt_nxt = '0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
          hold_nxt  = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      LONG_HELD: begin
        if (!p) begin
          state_nxt  = REL_DB;
          db_cnt_nxt = '0;
        end
      end

      REL_DB: begin
        if (p) begin
          state_nxt = hold_q ? LONG_HELD : HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
          hold_nxt  = 1'b0;
          short_nxt = !hold_q;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.btn_level   = level_q;
  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;
  assign bus.hold        = hold_q;

endmodule

// File: tb/tb_btn_press_detect.sv
// Directed bench: per-cycle btn_in patterns, outputs traced #1 after each edge and
// checked against hand-computed cycle numbers (DB=5, LONG=20 cycles).
module tb_btn_press_detect;

  typedef bit trace_t [0:255];

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_checks = 0;
  int     n_errors = 0;
  bit     pat [0:255];
  trace_t lv, sp, lp, hd;

  btn_press_detect_if bif ();

  btn_press_detect #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int lo, input int hi, input bit v);
    for (int i = lo; i <= hi; i++) pat[i] = v;
  endtask

  // pat[k] is driven just after edge k; trace index k+1 holds outputs after edge k+1.
  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      bif.btn_in = pat[k];
      @(posedge clk);
      #1;
      lv[k+1] = bif.btn_level;
      sp[k+1] = bif.short_press;
      lp[k+1] = bif.long_press;
      hd[k+1] = bif.hold;
    end
  endtask

  function automatic int first_one(input trace_t a, input int n);
    for (int i = 1; i <= n; i++) if (a[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones(input trace_t a, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(a[i]);
    return c;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_level"}, int'(bif.btn_level), 0);
    check({tag, "_short"}, int'(bif.short_press), 0);
    check({tag, "_long"},  int'(bif.long_press), 0);
    check({tag, "_hold"},  int'(bif.hold), 0);
  endtask

  // 15-cycle press: level up at 8, release at 15 gives short strobe and fall at 23.
  task automatic short_test(input string tag);
    fill(0, 14, 1'b0);
    fill(15, 39, 1'b1);
    play(40);
    check({tag, "_level_rise"},  first_one(lv, 40), 8);
    check({tag, "_short_at"},    first_one(sp, 40), 23);
    check({tag, "_short_cnt"},   count_ones(sp, 1, 40), 1);
    check({tag, "_level_22"},    int'(lv[22]), 1);
    check({tag, "_level_23"},    int'(lv[23]), 0);
    check({tag, "_long_cnt"},    count_ones(lp, 1, 40), 0);
    check({tag, "_hold_cnt"},    count_ones(hd, 1, 40), 0);
  endtask

  initial begin
    bif.btn_in = 1'b1;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Idle: button released for 100 cycles.
    fill(0, 99, 1'b1);
    play(100);
    check("idle_level", count_ones(lv, 1, 100), 0);
    check("idle_short", count_ones(sp, 1, 100), 0);
    check("idle_long",  count_ones(lp, 1, 100), 0);
    check("idle_hold",  count_ones(hd, 1, 100), 0);

    short_test("short");

    // Bounce: four 3-cycle low pulses separated by 2 high cycles.
    for (int i = 0; i < 4; i++) begin
      fill(5 * i, 5 * i + 2, 1'b0);
      fill(5 * i + 3, 5 * i + 4, 1'b1);
    end
    fill(20, 39, 1'b1);
    play(40);
    check("bounce_level", count_ones(lv, 1, 40), 0);
    check("bounce_short", count_ones(sp, 1, 40), 0);
    check("bounce_long",  count_ones(lp, 1, 40), 0);

    // Long: 60-cycle press, long strobe at 28, release falls at 68.
    fill(0, 59, 1'b0);
    fill(60, 79, 1'b1);
    play(80);
    check("long_at",       first_one(lp, 80), 28);
    check("long_cnt",      count_ones(lp, 1, 80), 1);
    check("long_hold_27",  int'(hd[27]), 0);
    check("long_hold_run", count_ones(hd, 28, 67), 40);
    check("long_hold_68",  int'(hd[68]), 0);
    check("long_level_67", int'(lv[67]), 1);
    check("long_level_68", int'(lv[68]), 0);
    check("long_short",    count_ones(sp, 1, 80), 0);
    check("long_both",     count_ones(sp, 1, 80) * count_ones(lp, 1, 80), 0);

    // Release glitch: 3 high cycles while HELD delay the long strobe by the frozen time.
    fill(0, 11, 1'b0);
    fill(12, 14, 1'b1);
    fill(15, 49, 1'b0);
    fill(50, 79, 1'b1);
    play(80);
    check("glitch_level_rise", first_one(lv, 80), 8);
    check("glitch_level_held", count_ones(lv, 8, 57), 50);
    check("glitch_level_58",   int'(lv[58]), 0);
    check("glitch_long_cnt",   count_ones(lp, 1, 80), 1);
    check("glitch_long_win",
          ((first_one(lp, 80) == 31) || (first_one(lp, 80) == 32)) ? 1 : 0, 1);
    check("glitch_short",      count_ones(sp, 1, 80), 0);

    // Reset while LONG_HELD, button released during reset.
    fill(0, 39, 1'b0);
    play(40);
    check("rstmid_hold_pre",  int'(hd[40]), 1);
    check("rstmid_level_pre", int'(lv[40]), 1);
    bif.btn_in = 1'b1;
    rst        = 1'b1;
    #1;
    check_outputs_zero("rstmid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fill(0, 29, 1'b1);
    play(30);
    check("after_rst_level", count_ones(lv, 1, 30), 0);
    check("after_rst_short", count_ones(sp, 1, 30), 0);
    check("after_rst_long",  count_ones(lp, 1, 30), 0);
    check("after_rst_hold",  count_ones(hd, 1, 30), 0);

    short_test("post_rst_short");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
